// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video stream types, FSM states and frame constants
package video_pkg;

   // Default frame geometry for the scan-out path
   localparam int FRAME_W = 160;
   localparam int FRAME_H = 120;

   // Sideband tags travel with each pixel as {eof, eol, sof}
   localparam int TAG_W   = 3;
   localparam int TAG_SOF = 0;
   localparam int TAG_EOL = 1;
   localparam int TAG_EOF = 2;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fr_state_t;

   // Builds the tag field in the bit order used by the output buffer
   function automatic logic [TAG_W-1:0] pack_tags(input logic sof, input logic eol, input logic eof);
      logic [TAG_W-1:0] t;
      t          = '0;
      t[TAG_SOF] = sof;
      t[TAG_EOL] = eol;
      t[TAG_EOF] = eof;
      return t;
   endfunction

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry valid/ready skid buffer with occupancy and flush
module stream_fifo2 #(
   parameter int DATA_W = 27
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic              i_s_tvalid,
   input  logic [DATA_W-1:0] i_s_tdata,
   output logic              o_m_tvalid,
   output logic [DATA_W-1:0] o_m_tdata,
   input  logic              i_m_tready,
   output logic [1:0]        o_occ
);

   logic [DATA_W-1:0] r_mem [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_occ;
   logic              w_push;
   logic              w_pop;

   // The producer only pushes when it has reserved a slot, so push is unconditional
   assign w_push     = i_s_tvalid;
   assign w_pop      = (r_occ != 2'd0) && i_m_tready;
   assign o_m_tvalid = (r_occ != 2'd0);
   assign o_m_tdata  = r_mem[r_rptr];
   assign o_occ      = r_occ;

   // Storage, pointers and occupancy; flush clears the entries so stale beats never reappear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_occ    <= 2'd0;
      end else if (i_flush) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_s_tdata;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // A push into a full buffer without a pop would overwrite the head beat
   assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && !w_pop && !i_flush && (r_occ == 2'd2)));

endmodule

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - raster scan-out of a pixel RAM onto a tagged valid/ready stream
module frame_reader
   import video_pkg::*;
#(
   parameter int WIDTH  = FRAME_W,
   parameter int HEIGHT = FRAME_H,
   parameter int PIX_W  = 24,
   parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [PIX_W-1:0]  m_pixel,
   output logic              m_sof,
   output logic              m_eol,
   output logic              m_eof
);

   localparam int N_PIX = WIDTH * HEIGHT;
   localparam int X_W   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int Y_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int BEAT_W = PIX_W + TAG_W;
   localparam logic [X_W-1:0]    X_LAST = X_W'(WIDTH - 1);
   localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(N_PIX - 1);

   fr_state_t          r_state;
   logic [X_W-1:0]     r_x;
   logic [Y_W-1:0]     r_y;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_inflight;
   logic [TAG_W-1:0]   r_tag_d;

   logic               w_hs;
   logic               w_issue;
   logic               w_last;
   logic               w_done;
   logic [1:0]         w_occ;
   logic [2:0]         w_load;
   logic [TAG_W-1:0]   w_tags;
   logic [BEAT_W-1:0]  w_head;
   logic               w_push;

   assign w_hs   = m_valid && m_ready;

   // Slots committed next cycle: buffered beats (minus one leaving now) plus the read in flight
   assign w_load = {1'b0, w_occ} - {2'b00, w_hs} + {2'b00, r_inflight};
   assign w_issue = (r_state == RUN) && !abort && (w_load < 3'd2);
   assign w_last  = (r_addr == A_LAST);
   assign w_tags  = pack_tags((r_x == '0) && (r_y == '0), (r_x == X_LAST), w_last);

   // The eof handshake ends the frame; an abort in the same cycle suppresses the pulse
   assign w_done = (r_state == DRAIN) && w_hs && m_eof && !abort;

   // Returning read data is buffered only when it answers a real read and no abort is pending
   assign w_push = r_inflight && !abort;

   // Scan FSM with x/y/address counters; rd_addr holds the last issued address after the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_addr  <= '0;
      end else if (abort) begin
         r_state <= IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  r_x     <= '0;
                  r_y     <= '0;
                  r_addr  <= '0;
               end
            end
            RUN: begin
               if (w_issue) begin
                  if (w_last) begin
                     r_state <= DRAIN;
                  end else begin
                     r_addr <= r_addr + ADDR_W'(1);
                     if (r_x == X_LAST) begin
                        r_x <= '0;
                        r_y <= r_y + Y_W'(1);
                     end else begin
                        r_x <= r_x + X_W'(1);
                     end
                  end
               end
            end
            DRAIN: begin
               if (w_done) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Tags ride one cycle behind the read strobe so they meet rd_data at the buffer input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
         r_tag_d    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_tag_d <= w_tags;
         end
      end
   end

   stream_fifo2 #(
      .DATA_W (BEAT_W)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_flush    (abort),
      .i_s_tvalid (w_push),
      .i_s_tdata  ({r_tag_d, rd_data}),
      .o_m_tvalid (m_valid),
      .o_m_tdata  (w_head),
      .i_m_tready (m_ready),
      .o_occ      (w_occ)
   );

   assign busy    = (r_state != IDLE);
   assign done    = w_done;
   assign rd_en   = w_issue;
   assign rd_addr = r_addr;
   assign m_pixel = w_head[PIX_W-1:0];
   assign m_sof   = w_head[PIX_W + TAG_SOF];
   assign m_eol   = w_head[PIX_W + TAG_EOL];
   assign m_eof   = w_head[PIX_W + TAG_EOF];

endmodule
